riscv_dcache_data_nway: RTL

//  N-way set-associative L1 D-cache data array: 128-bit lines, byte-enabled CPU stores, 1-cycle registered reads.

---
 rtl/riscv_dcache_data_nway.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_dcache_data_nway.sv
// riscv_dcache_data_nway: N-way L1 D-cache data array.
// Byte-enabled CPU stores, 1-cycle registered reads of all ways, multi-beat
// refill and victim streaming. All state moves on the falling clock edge.
// Optional: define DCACHE_DATA_PARITY_EN for per-byte even parity checking.
module riscv_dcache_data_nway #(
  parameter int WAYS       = 2,
  parameter int INDEX      = 8,
  parameter int LINE_BYTES = 16,
  parameter int BEAT_W     = 32,
  localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int LINE_W    = 8 * LINE_BYTES,
  localparam int OFF_W     = $clog2(LINE_BYTES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_rden,
  input  logic                     cpu_wren,
  input  logic [WAY_BITS-1:0]      cpu_way,
  input  logic [INDEX-1:0]         cpu_index,
  input  logic [OFF_W-1:0]         byte_offset,
  input  logic [1:0]               storesrc,
  input  logic [63:0]              cpu_wdata,
  output logic [WAYS*LINE_W-1:0]   rd_data,
  input  logic                     fill_start,
  input  logic [WAY_BITS-1:0]      fill_way,
  input  logic [INDEX-1:0]         fill_index,
  input  logic                     fill_valid,
  input  logic [BEAT_W-1:0]        fill_data,
  output logic                     fill_ready,
  output logic                     fill_done,
  input  logic                     evict_start,
  input  logic [WAY_BITS-1:0]      evict_way,
  input  logic [INDEX-1:0]         evict_index,
  output logic                     evict_valid,
  output logic [BEAT_W-1:0]        evict_data,
  output logic                     evict_last,
  input  logic                     evict_ready,
  output logic                     busy,
  output logic [WAYS-1:0]          parity_err
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DEPTH = 2 ** INDEX;
  localparam int BB    = BEAT_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVLD, S_EV} state_t;

  logic [LINE_W-1:0]     mem_q [WAYS][DEPTH];
  state_t                state_q;
  logic [CNT_W-1:0]      beat_cnt_q, cnt_nxt;
  logic [WAY_BITS-1:0]   way_q;
  logic [INDEX-1:0]      idx_q;
  logic [LINE_W-1:0]     ev_line_q;
  logic [WAYS*LINE_W-1:0] rd_data_q;
  logic                  fill_ready_q, fill_done_q, evict_valid_q, evict_last_q, busy_q;
  logic [BEAT_W-1:0]     evict_data_q;

  logic                  cpu_ok, cpu_rd, cpu_we, fill_we, fill_last;
  logic [OFF_W-1:0]      sz_m1;
  logic [LINE_BYTES-1:0] wbe;
  logic [LINE_W-1:0]     wline;

  // CPU access only lands in IDLE when no burst is starting; a combined read+write is a read.
  assign cpu_ok    = (state_q == S_IDLE) && !fill_start && !evict_start;
  assign cpu_rd    = cpu_ok && cpu_rden;
  assign cpu_we    = cpu_ok && cpu_wren && !cpu_rden;
  assign fill_we   = (state_q == S_FILL) && fill_valid;
  assign fill_last = (beat_cnt_q == CNT_W'(BEATS - 1));
  assign cnt_nxt   = beat_cnt_q + 1'b1;

  // Store data replicated per size and tiled; enables cover the aligned container of byte_offset.
  always_comb begin
    case (storesrc)
      2'b00:   sz_m1 = OFF_W'(0);
      2'b01:   sz_m1 = OFF_W'(1);
      2'b10:   sz_m1 = OFF_W'(3);
      default: sz_m1 = OFF_W'(7);
    endcase
    wbe   = '0;
    wline = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      wbe[i]          = ((OFF_W'(i) & ~sz_m1) == (byte_offset & ~sz_m1));
      wline[8*i +: 8] = cpu_wdata[8*(i & int'(sz_m1)) +: 8];
    end
  end

  // Data array writes: refill beats and byte-enabled CPU stores, blocked during reset.
  always_ff @(negedge clk) begin
    if (rst_n) begin
      if (fill_we)
        mem_q[way_q][idx_q][beat_cnt_q*BEAT_W +: BEAT_W] <= fill_data;
      if (cpu_we)
        for (int i = 0; i < LINE_BYTES; i++)
          if (wbe[i]) mem_q[cpu_way][cpu_index][8*i +: 8] <= wline[8*i +: 8];
    end
  end

  // Control FSM: idle/refill/evict-load/evict-stream plus registered read port.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      beat_cnt_q    <= '0;
      way_q         <= '0;
      idx_q         <= '0;
      ev_line_q     <= '0;
      rd_data_q     <= '0;
      fill_ready_q  <= 1'b0;
      fill_done_q   <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      evict_last_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      if (cpu_rd)
        for (int w = 0; w < WAYS; w++) rd_data_q[w*LINE_W +: LINE_W] <= mem_q[w][cpu_index];
      case (state_q)
        S_IDLE: begin
          if (evict_start) begin
            way_q   <= evict_way;
            idx_q   <= evict_index;
            state_q <= S_EVLD;
            busy_q  <= 1'b1;
          end else if (fill_start) begin
            way_q        <= fill_way;
            idx_q        <= fill_index;
            state_q      <= S_FILL;
            fill_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        S_FILL: begin
          if (fill_valid) begin
            if (fill_last) begin
              beat_cnt_q   <= '0;
              fill_ready_q <= 1'b0;
              fill_done_q  <= 1'b1;
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
            end else begin
              beat_cnt_q <= cnt_nxt;
            end
          end
        end
        S_EVLD: begin
          ev_line_q     <= mem_q[way_q][idx_q];
          evict_data_q  <= mem_q[way_q][idx_q][BEAT_W-1:0];
          evict_valid_q <= 1'b1;
          evict_last_q  <= 1'b0;
          state_q       <= S_EV;
        end
        S_EV: begin
          if (evict_ready) begin
            if (evict_last_q) begin
              evict_valid_q <= 1'b0;
              evict_last_q  <= 1'b0;
              beat_cnt_q    <= '0;
              state_q       <= S_IDLE;
              busy_q        <= 1'b0;
            end else begin
              beat_cnt_q   <= cnt_nxt;
              evict_data_q <= ev_line_q[cnt_nxt*BEAT_W +: BEAT_W];
              evict_last_q <= (cnt_nxt == CNT_W'(BEATS - 1));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data     = rd_data_q;
  assign fill_ready  = fill_ready_q;
  assign fill_done   = fill_done_q;
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;
  assign evict_last  = evict_last_q;
  assign busy        = busy_q;

`ifdef DCACHE_DATA_PARITY_EN
  logic [LINE_BYTES-1:0] par_q [WAYS][DEPTH];
  logic [LINE_BYTES-1:0] ev_par_q;
  logic [WAYS-1:0]       rd_perr_q, ev_perr_q;
  logic [BB-1:0]         fill_par;
  logic                  ev_bad;

  // Per-byte parity of the incoming refill beat and mismatch check of the outgoing evict beat.
  always_comb begin
    ev_bad = 1'b0;
    for (int i = 0; i < BB; i++) begin
      fill_par[i] = ^fill_data[8*i +: 8];
      ev_bad      = ev_bad | ((^evict_data_q[8*i +: 8]) ^ ev_par_q[int'(beat_cnt_q)*BB + i]);
    end
  end

  // Parity array follows every data array write.
  always_ff @(negedge clk) begin
    if (rst_n) begin
      if (fill_we) par_q[way_q][idx_q][beat_cnt_q*BB +: BB] <= fill_par;
      if (cpu_we)
        for (int i = 0; i < LINE_BYTES; i++)
          if (wbe[i]) par_q[cpu_way][cpu_index][i] <= ^wline[8*i +: 8];
    end
  end

  // Read-side parity flags track rd_data; evict flags pulse for one cycle per bad beat.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      rd_perr_q <= '0;
      ev_perr_q <= '0;
      ev_par_q  <= '0;
    end else begin
      ev_perr_q <= '0;
      if (cpu_rd)
        for (int w = 0; w < WAYS; w++) begin
          logic [LINE_BYTES-1:0] p;
          for (int i = 0; i < LINE_BYTES; i++) p[i] = ^mem_q[w][cpu_index][8*i +: 8];
          rd_perr_q[w] <= |(p ^ par_q[w][cpu_index]);
        end
      if (state_q == S_EVLD) ev_par_q <= par_q[way_q][idx_q];
      if (state_q == S_EV && evict_valid_q && evict_ready && ev_bad) ev_perr_q[way_q] <= 1'b1;
    end
  end

  assign parity_err = rd_perr_q | ev_perr_q;
`else
  assign parity_err = '0;
`endif

endmodule
